mdu_scheduler: RTL and testbench
================================

// Module: mdu_scheduler
// PURPOSE
//   Sequences the shared multiply/divide resource for the E stage: accepts mult/multu/div/divu/mthi/mtlo,
//   runs a fixed-latency busy window, commits HI/LO, and raises a D-stage stall for any MD-class
//   instruction while the unit is busy. Its HI/LO outputs feed mfhi/mflo forwarding and write-back.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
//   CNT_W        4   counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//   clk      in   1   clock, rising edge
//   reset    in   1   asynchronous, active-high; clears all state
//   start    in   1   E-stage issue strobe, qualifies md_op for one cycle
//   md_op    in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (= none)
//   cancel   in   1   exception/flush request this cycle; blocks the issue in the same cycle
//   a        in   32  rs operand (dividend / mthi-mtlo source)
//   b        in   32  rt operand (divisor)
//   d_is_md  in   1   D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//   busy     out  1   computation in flight
//   done     out  1   one-cycle pulse in the final busy cycle
//   stall    out  1   d_is_md & (busy | (start & md_op in 1..4 & ~cancel)); combinational
//   hi       out  32  architectural HI
//   lo       out  32  architectural LO
// BEHAVIOUR
//   Reset: busy=0, done=0, hi=0, lo=0, counter=0, state IDLE, pending result=0. Takes effect immediately.
//   States: IDLE, RUN.
//   - IDLE: start & ~cancel & md_op in 1..4 -> RUN. Operands are evaluated at the issue edge into
//     pending_hi/pending_lo. Counter loads MULT_CYCLES or DIV_CYCLES.
//   - RUN: counter decrements each cycle. busy=1 for cycles T+1..T+N, where T is the issue cycle.
//     done=1 in cycle T+N. At the T+N edge, hi/lo <= pending and the block returns to IDLE.
//     hi/lo show the new values from T+N+1.
//   - mthi/mtlo: in IDLE, with start & ~cancel, hi (or lo) <= a at the next edge (1-cycle latency).
//     In RUN they are ignored; the pipeline prevents this case via stall.
//   - Arithmetic:
//       mult:  {hi,lo} = $signed(a)*$signed(b), 64-bit.
//       multu: same, unsigned.
//       div:   lo = signed quotient truncated toward zero; hi = remainder, taking the sign of the dividend.
//       divu:  unsigned quotient/remainder.
//       0x80000000 / -1 (div): lo=0x80000000, hi=0.
//   - start while busy: ignored. Counter and pending result are unchanged. Not an error output.
//   - cancel: masks issue only. An in-flight operation is NOT aborted and still commits HI/LO.
//   - reset mid-RUN: aborts at once. No done pulse; hi/lo are 0.
//   - Back-to-back: a new start is accepted in cycle T+N+1 (first IDLE cycle). There is no overlap with done.
// CONFIGURATION
//   DIV_ZERO_FAST_EN
//     defined:   div/divu with b==0 leave hi/lo unchanged, and busy/done last 1 cycle (N=1).
//     undefined: b==0 takes the full DIV_CYCLES and commits hi=a, lo=32'hFFFFFFFF.
//     Never produces X in either case.
// TESTING
//   1. mult a=32'hFFFFFFFD (-3), b=7 at T -> busy T+1..T+5, done at T+5; at T+6 hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
//   2. divu a=100, b=7 -> busy 10 cycles; then lo=14, hi=2. Re-issue multu 2x3 at T+11 -> lo=6, hi=0 at T+17.
//   3. div a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. div 32'h80000000 by -1 -> lo=32'h80000000, hi=0.
//   4. start mult with cancel=1 -> busy stays 0, hi/lo unchanged. mtlo a=5 with cancel=1 -> lo unchanged.
//      mtlo a=5 without cancel -> lo=5 next cycle.
//   5. d_is_md=1 held from the issue cycle onward -> stall=1 in T..T+N, 0 from T+N+1.
//      With d_is_md=0 -> stall=0 throughout.
//   6. reset pulse at T+3 of a div -> busy=0 and hi=lo=0 immediately, no done. div b=0 -> hi/lo unchanged
//      after 1 cycle with DIV_ZERO_FAST_EN, else hi=a, lo=32'hFFFFFFFF after 10 cycles.

Source files
------------

// File: rtl/mdu_scheduler.sv
// Multiply/divide sequencer for the E stage: fixed-latency busy window, HI/LO commit, D-stage stall.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero finishes in one cycle and leaves HI/LO untouched.
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi, pend_lo;

    logic             is_calc, issue, div_zero;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      dvs, mag_a, mag_b, uq, ur, sq_mag, sr_mag, sq, sr;
    logic [31:0]      nxt_hi, nxt_lo;
    logic [CNT_W-1:0] nxt_cyc;

    assign is_calc = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign issue   = start & ~cancel & (state == IDLE);
    assign busy    = (state == RUN);
    assign done    = busy & (cnt == CNT_W'(1));
    assign stall   = d_is_md & (busy | (start & is_calc & ~cancel));

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divisor forced to 1 on zero so the datapath never produces X; the result is overridden below.
    assign div_zero = (b == 32'd0);
    assign dvs      = div_zero ? 32'd1 : b;
    assign uq       = a / dvs;
    assign ur       = a % dvs;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend,
    // and 0x80000000 / -1 wraps naturally to 0x80000000 remainder 0.
    assign mag_a  = a[31] ? (32'd0 - a) : a;
    assign mag_b  = b[31] ? (32'd0 - dvs) : dvs;
    assign sq_mag = mag_a / mag_b;
    assign sr_mag = mag_a % mag_b;
    assign sq     = (a[31] ^ b[31]) ? (32'd0 - sq_mag) : sq_mag;
    assign sr     = a[31] ? (32'd0 - sr_mag) : sr_mag;

    always_comb begin
        nxt_hi  = hi;
        nxt_lo  = lo;
        nxt_cyc = CNT_W'(MULT_CYCLES);
        case (md_op)
            OP_MULT:  {nxt_hi, nxt_lo} = prod_s;
            OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
            OP_DIV: begin
                nxt_hi  = sr;
                nxt_lo  = sq;
                nxt_cyc = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                nxt_hi  = ur;
                nxt_lo  = uq;
                nxt_cyc = CNT_W'(DIV_CYCLES);
            end
            default: ;
        endcase
        if ((md_op == OP_DIV || md_op == OP_DIVU) && div_zero) begin
`ifdef DIV_ZERO_FAST_EN
            nxt_hi  = hi;
            nxt_lo  = lo;
            nxt_cyc = CNT_W'(1);
`else
            nxt_hi  = a;
            nxt_lo  = 32'hFFFF_FFFF;
            nxt_cyc = CNT_W'(DIV_CYCLES);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (state == IDLE) begin
            if (issue && is_calc) begin
                state   <= RUN;
                cnt     <= nxt_cyc;
                pend_hi <= nxt_hi;
                pend_lo <= nxt_lo;
            end else if (issue && md_op == OP_MTHI) begin
                hi <= a;
            end else if (issue && md_op == OP_MTLO) begin
                lo <= a;
            end
        end else begin
            // Cancel and new starts are ignored here; the in-flight result always commits.
            if (cnt == CNT_W'(1)) begin
                state <= IDLE;
                cnt   <= '0;
                hi    <= pend_hi;
                lo    <= pend_lo;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler: cycle-count reference model checked every negedge plus literal pins.
module tb_mdu_scheduler;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic        cancel = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        d_is_md = 1'b0;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .cancel(cancel),
        .a(a), .b(b), .d_is_md(d_is_md), .busy(busy), .done(done), .stall(stall),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the edge index at which the in-flight result commits.
    int          k = 0;
    int          m_commit = 0;
    bit          m_busy = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] vb);
        if (op == 3'd1 || op == 3'd2) return MC;
`ifdef DIV_ZERO_FAST_EN
        if (vb == 0) return 1;
`endif
        return DC;
    endfunction

    function automatic logic [63:0] res_of(input logic [2:0] op, input logic [31:0] va,
                                           input logic [31:0] vb, input logic [63:0] cur);
        longint q, r;
        logic [63:0] p;
        case (op)
            3'd1: p = longint'($signed(va)) * longint'($signed(vb));
            3'd2: p = {32'd0, va} * {32'd0, vb};
            default: begin
                if (vb == 0) begin
`ifdef DIV_ZERO_FAST_EN
                    p = cur;
`else
                    p = {va, 32'hFFFF_FFFF};
`endif
                end else if (op == 3'd3) begin
                    q = longint'($signed(va)) / longint'($signed(vb));
                    r = longint'($signed(va)) % longint'($signed(vb));
                    p = {r[31:0], q[31:0]};
                end else begin
                    q = longint'({32'd0, va}) / longint'({32'd0, vb});
                    r = longint'({32'd0, va}) % longint'({32'd0, vb});
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k <= 0; m_busy <= 0; m_hi <= 0; m_lo <= 0; m_commit <= 0;
        end else begin
            k <= k + 1;
            if (m_busy) begin
                if (k + 1 == m_commit) begin
                    m_hi <= m_phi; m_lo <= m_plo; m_busy <= 0;
                end
            end else if (start && !cancel) begin
                if (md_op >= 3'd1 && md_op <= 3'd4) begin
                    m_busy   <= 1;
                    m_commit <= k + 1 + lat_of(md_op, b);
                    {m_phi, m_plo} <= res_of(md_op, a, b, {m_hi, m_lo});
                end else if (md_op == 3'd5) m_hi <= a;
                else if (md_op == 3'd6) m_lo <= a;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {63'd0, busy}, {63'd0, m_busy});
        chk("done", {63'd0, done}, {63'd0, m_busy && (k + 1 == m_commit)});
        chk("stall", {63'd0, stall},
            {63'd0, d_is_md && (m_busy || (start && !cancel && md_op >= 3'd1 && md_op <= 3'd4))});
        chk("hi", {32'd0, hi}, {32'd0, m_hi});
        chk("lo", {32'd0, lo}, {32'd0, m_lo});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input bit vc);
        start = 1; md_op = op; a = va; b = vb; cancel = vc;
        tick();
        start = 0; md_op = 0; cancel = 0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 0;
        tick();

        // 1: mult -3 * 7
        issue(3'd1, 32'hFFFF_FFFD, 32'd7, 0);
        repeat (4) tick();
        chk("t1_done", {63'd0, done}, 64'd1);
        tick();
        chk("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("t1_idle", {63'd0, busy}, 64'd0);

        // 2: divu 100/7, start while busy ignored, back-to-back multu
        issue(3'd4, 32'd100, 32'd7, 0);
        repeat (3) tick();
        issue(3'd1, 32'd9, 32'd9, 0);
        repeat (5) tick();
        chk("t2_done", {63'd0, done}, 64'd1);
        tick();
        chk("t2_hilo", {hi, lo}, {32'd2, 32'd14});
        issue(3'd2, 32'd2, 32'd3, 0);
        repeat (5) tick();
        chk("t2_multu", {hi, lo}, {32'd0, 32'd6});

        // 3: signed division cases
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        repeat (10) tick();
        chk("t3_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        repeat (10) tick();
        chk("t3_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

        // 4: cancel masks issue; mtlo
        issue(3'd1, 32'd4, 32'd4, 1);
        chk("t4_nobusy", {63'd0, busy}, 64'd0);
        issue(3'd6, 32'd5, 32'd0, 1);
        chk("t4_mtlo_cx", {32'd0, lo}, {32'd0, 32'h8000_0000});
        issue(3'd6, 32'd5, 32'd0, 0);
        chk("t4_mtlo", {32'd0, lo}, 64'd5);

        // 5: stall window with d_is_md held
        d_is_md = 1;
        start = 1; md_op = 3'd1; a = 32'd3; b = 32'd3;
        #1 chk("t5_stall_T", {63'd0, stall}, 64'd1);
        tick();
        start = 0; md_op = 0;
        for (int i = 1; i <= MC; i++) begin
            chk("t5_stall_run", {63'd0, stall}, 64'd1);
            tick();
        end
        chk("t5_stall_off", {63'd0, stall}, 64'd0);
        d_is_md = 0;
        start = 1; md_op = 3'd2; a = 32'd1; b = 32'd1;
        #1 chk("t5_nostall", {63'd0, stall}, 64'd0);
        tick();
        start = 0; md_op = 0;
        repeat (MC) tick();

        // 6: reset mid-run, then divide by zero
        issue(3'd3, 32'd5, 32'd3, 0);
        repeat (2) tick();
        reset = 1;
        #1 chk("t6_rst_busy", {62'd0, busy, done}, 64'd0);
        chk("t6_rst_hilo", {hi, lo}, 64'd0);
        tick();
        reset = 0;
        tick();
        issue(3'd5, 32'h1234, 32'd0, 0);
        issue(3'd6, 32'h5678, 32'd0, 0);
        issue(3'd3, 32'd9, 32'd0, 0);
`ifdef DIV_ZERO_FAST_EN
        chk("t6_dz_done", {63'd0, done}, 64'd1);
        tick();
        chk("t6_dz_hilo", {hi, lo}, {32'h1234, 32'h5678});
`else
        repeat (9) tick();
        chk("t6_dz_done", {63'd0, done}, 64'd1);
        tick();
        chk("t6_dz_hilo", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
`endif
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
